// File: rtl/nonce_transmit_pkg.sv
// Shared definitions for the nonce return path: FSM states, UART frame
// geometry and the MSB-first byte selector used by the top level.
package nonce_transmit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned START_BITS      = 1;
    localparam int unsigned STOP_BITS       = 1;
    localparam int unsigned FRAME_BITS      = START_BITS + DATA_BITS + STOP_BITS;
    localparam int unsigned BYTES_PER_NONCE = 4;
    localparam int unsigned NONCE_BITS      = DATA_BITS * BYTES_PER_NONCE;
    localparam int unsigned IDX_W           = $clog2(BYTES_PER_NONCE);

    // Byte 0 is the most significant byte so the host's shift-left
    // assembly rebuilds the original word.
    function automatic logic [DATA_BITS-1:0] nonce_byte(
        input logic [NONCE_BITS-1:0] word,
        input logic [IDX_W-1:0]      idx
    );
        logic [DATA_BITS-1:0] sel;
        case (idx)
            2'd0:    sel = word[31:24];
            2'd1:    sel = word[23:16];
            2'd2:    sel = word[15:8];
            default: sel = word[7:0];
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/nonce_transmit_uart.sv
// 8N1 UART transmitter: BIT-cycle baud counter and a 10-bit frame shift
// register. tx_ready is high during the final cycle of the stop bit so a
// controller can react on the edge where the stop bit completes.
module uart_transmitter
    import nonce_transmit_pkg::*;
#(
    parameter int unsigned comm_clk_frequency = 100000000,
    parameter int unsigned baud_rate          = 115200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_new_byte,
    input  logic [DATA_BITS-1:0] tx_byte,
    output logic                 uart_tx,
    output logic                 tx_ready
);

    localparam int unsigned BIT    = comm_clk_frequency / baud_rate;
    localparam int unsigned CNT_W  = (BIT > 1) ? $clog2(BIT) : 1;
    localparam int unsigned BITS_W = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BIT - 1);
    localparam logic [BITS_W-1:0] BIT_LAST  = BITS_W'(FRAME_BITS - 1);

    logic                  active_q, active_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [BITS_W-1:0]     bit_q, bit_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  bit_done;

    // The line is driven straight from the shift register LSB, which is
    // filled with ones so it idles high between frames.
    assign uart_tx  = shreg_q[0];
    assign bit_done = active_q && (baud_q == BAUD_LAST);
    assign tx_ready = bit_done && (bit_q == BIT_LAST);

    // Next-state: load a new frame, or advance the baud/bit counters.
    always_comb begin
        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        if (tx_new_byte) begin
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = '0;
            shreg_d  = {{STOP_BITS{1'b1}}, tx_byte, 1'b0};
        end else if (active_q) begin
            if (bit_done) begin
                baud_d  = '0;
                shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
                if (bit_q == BIT_LAST) begin
                    active_d = 1'b0;
                    bit_d    = '0;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset to an idle-high line.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '1;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
        end
    end

endmodule

// File: rtl/nonce_transmit.sv
// Returns found nonces to the host as four UART bytes, MSB first. One
// pending slot absorbs a second find while a word is on the line; further
// finds are dropped and flagged by the sticky overflow output.
module nonce_transmit
    import nonce_transmit_pkg::*;
#(
    parameter int unsigned comm_clk_frequency = 100000000,
    parameter int unsigned baud_rate          = 115200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NONCE_BITS-1:0] nonce,
    input  logic                  new_nonce,
    output logic                  TxD,
    output logic                  busy,
    output logic                  overflow
);

    tx_state_e             state_q;
    logic [NONCE_BITS-1:0] active_q;
    logic [NONCE_BITS-1:0] pend_q;
    logic                  pend_valid_q;
    logic [IDX_W-1:0]      byte_idx_q;
    logic                  tx_new_byte_q;
    logic                  overflow_q;

    logic                  tx_ready;
    logic [DATA_BITS-1:0]  tx_byte;
    logic                  last_byte;
    logic                  word_handoff;

    assign last_byte    = (byte_idx_q == IDX_W'(BYTES_PER_NONCE - 1));
    assign word_handoff = (state_q == ST_GAP) && last_byte;
    assign tx_byte      = nonce_byte(active_q, byte_idx_q);
    assign busy         = (state_q != ST_IDLE) || pend_valid_q;
    assign overflow     = overflow_q;

    uart_transmitter #(
        .comm_clk_frequency(comm_clk_frequency),
        .baud_rate         (baud_rate)
    ) u_uart (
        .clk        (clk),
        .reset      (reset),
        .tx_new_byte(tx_new_byte_q),
        .tx_byte    (tx_byte),
        .uart_tx    (TxD),
        .tx_ready   (tx_ready)
    );

    // Word sequencer, pending slot and overflow flag. tx_new_byte is set on
    // the edge entering LOAD so the UART loads on the edge leaving LOAD,
    // giving exactly one GAP and one LOAD cycle between stop and start bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            active_q      <= '0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            byte_idx_q    <= '0;
            tx_new_byte_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            tx_new_byte_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (new_nonce) begin
                        active_q      <= nonce;
                        byte_idx_q    <= '0;
                        tx_new_byte_q <= 1'b1;
                        state_q       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    tx_new_byte_q <= 1'b1;
                    state_q       <= ST_LOAD;
                    if (!last_byte) begin
                        byte_idx_q <= byte_idx_q + 1'b1;
                    end else begin
                        byte_idx_q <= '0;
                        if (pend_valid_q) begin
                            // Pending word launches; a strobe here refills the freed slot.
                            active_q     <= pend_q;
                            pend_valid_q <= new_nonce;
                            if (new_nonce) begin
                                pend_q <= nonce;
                            end
                        end else if (new_nonce) begin
                            active_q <= nonce;
                        end else begin
                            tx_new_byte_q <= 1'b0;
                            state_q       <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Strobes arriving mid-word fill the pending slot or are dropped.
            if (new_nonce && (state_q != ST_IDLE) && !word_handoff) begin
                if (!pend_valid_q) begin
                    pend_q       <= nonce;
                    pend_valid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nonce_transmit.sv
// Self-checking bench for nonce_transmit at BIT=8: a timeline model of the
// line plus a UART decoder for hand-computed byte and spacing checks.
`timescale 1ns/1ps
module tb_nonce_transmit;

    localparam int CLK_HZ    = 800;
    localparam int BAUD      = 100;
    localparam int B         = CLK_HZ / BAUD;      // 8 cycles per bit
    localparam int BYTE_SPAN = 10 * B + 2;         // start-edge to start-edge
    localparam int WORD_SPAN = 4 * BYTE_SPAN;      // launch edge to next launch edge

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_nonce = 1'b0;
    logic [31:0] nonce = '0;
    logic        TxD, busy, overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_strobe = 0;

    nonce_transmit #(
        .comm_clk_frequency(CLK_HZ),
        .baud_rate         (BAUD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .nonce    (nonce),
        .new_nonce(new_nonce),
        .TxD      (TxD),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    logic [31:0] m_act = '0, m_pend = '0;
    bit          m_act_v = 1'b0, m_pend_v = 1'b0, m_ovf = 1'b0;
    int          m_ph = 0;   // edges since the current word was launched

    function automatic logic exp_line(input logic [31:0] w, input int p);
        int rel, b, off, k;
        logic [7:0] by;
        if (p < 1) return 1'b1;
        rel = p - 1;
        b   = rel / BYTE_SPAN;
        off = rel % BYTE_SPAN;
        if (b > 3 || off >= 10 * B) return 1'b1;
        k = off / B;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        by = w[31 - 8 * b -: 8];
        return by[k - 1];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_act_v = 1'b0; m_pend_v = 1'b0; m_ovf = 1'b0; m_ph = 0;
        end else if (m_act_v && m_ph == WORD_SPAN - 1) begin
            if (m_pend_v) begin
                m_act = m_pend; m_ph = 0;
                if (new_nonce) m_pend = nonce; else m_pend_v = 1'b0;
            end else if (new_nonce) begin
                m_act = nonce; m_ph = 0;
            end else begin
                m_act_v = 1'b0;
            end
        end else if (m_act_v) begin
            m_ph++;
            if (new_nonce) begin
                if (!m_pend_v) begin m_pend = nonce; m_pend_v = 1'b1; end
                else m_ovf = 1'b1;
            end
        end else if (new_nonce) begin
            m_act = nonce; m_act_v = 1'b1; m_ph = 0;
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("txd", TxD, m_act_v ? exp_line(m_act, m_ph) : 1'b1);
            chk("busy", busy, m_act_v || m_pend_v);
            chk("overflow", overflow, m_ovf);
        end
    end

    // ---------------- line decoder ----------------
    logic [7:0] rx_q[$];
    int         rx_start[$];
    logic       prev_txd = 1'b1;
    bit         dec_on = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = '0;

    always @(negedge clk) begin
        if (dec_on) begin
            dec_cnt++;
            if ((dec_cnt % B) == B / 2 && dec_cnt / B >= 1 && dec_cnt / B <= 8)
                dec_byte[dec_cnt / B - 1] = TxD;
            if (dec_cnt == 10 * B - 1) begin
                dec_on = 1'b0;
                rx_q.push_back(dec_byte);
            end
        end else if (prev_txd === 1'b1 && TxD === 1'b0) begin
            dec_on = 1'b1;
            dec_cnt = 0;
            rx_start.push_back(cyc);
        end
        prev_txd = TxD;
    end

    task automatic clear_rx();
        rx_q.delete();
        rx_start.delete();
        dec_on = 1'b0;
        prev_txd = 1'b1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic strobe_at(input logic [31:0] v, input int e);
        @(negedge clk);
        while (cyc < e - 1) @(negedge clk);
        nonce = v; new_nonce = 1'b1; last_strobe = cyc;
        @(negedge clk);
        new_nonce = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int fall);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 1'b0);
        fall = cyc;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_word(input string name, input int base, input logic [31:0] w);
        logic [31:0] got;
        got = '0;
        for (int i = 0; i < 4; i++)
            if (base + i < rx_q.size()) got[31 - 8 * i -: 8] = rx_q[base + i];
        chk(name, got, w);
    endtask

    initial begin : watchdog
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int fall, lows, s0;

        // Reset held for three edges
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_txd", TxD, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ovf", overflow, 1'b0);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (TxD !== 1'b1) lows++;
        end
        chk("idle_line_lows", lows, 0);

        // Single word
        clear_rx();
        strobe_at(32'hDEADBEEF, 0);
        s0 = last_strobe;
        wait_idle("single_idle", fall);
        chk("single_nbytes", rx_q.size(), 4);
        chk_word("single_word", 0, 32'hDEADBEEF);
        chk("single_first_fall", rx_start[0] - s0, 2);
        chk("single_gap01", rx_start[1] - rx_start[0], 82);
        chk("single_gap12", rx_start[2] - rx_start[1], 82);
        chk("single_gap23", rx_start[3] - rx_start[2], 82);
        chk("single_busy_fall", fall - rx_start[0], 327);

        // Queued word during byte 1
        repeat (5) @(negedge clk);
        clear_rx();
        strobe_at(32'h11223344, 0);
        s0 = last_strobe;
        strobe_at(32'h55667788, s0 + 120);
        wait_idle("queued_idle", fall);
        chk("queued_nbytes", rx_q.size(), 8);
        chk_word("queued_w0", 0, 32'h11223344);
        chk_word("queued_w1", 4, 32'h55667788);
        chk("queued_word_gap", rx_start[4] - rx_start[3], 82);
        chk("queued_ovf", overflow, 1'b0);

        // Overflow: third strobe during one word is dropped
        repeat (5) @(negedge clk);
        clear_rx();
        strobe_at(32'hA1B2C3D4, 0);
        s0 = last_strobe;
        strobe_at(32'h0BADF00D, s0 + 50);
        strobe_at(32'hC0C0C0C0, s0 + 200);
        wait_idle("ovf_idle", fall);
        chk("ovf_nbytes", rx_q.size(), 8);
        chk_word("ovf_wA", 0, 32'hA1B2C3D4);
        chk_word("ovf_wB", 4, 32'h0BADF00D);
        repeat (20) @(negedge clk);
        chk("ovf_sticky", overflow, 1'b1);
        do_reset(2);
        chk("ovf_cleared", overflow, 1'b0);

        // Boundary: C strobed on the edge leaving A's last GAP with B pending
        repeat (5) @(negedge clk);
        clear_rx();
        strobe_at(32'hCAFEF00D, 0);
        s0 = last_strobe;
        strobe_at(32'h12345678, s0 + 100);
        strobe_at(32'h9ABCDEF1, s0 + 1 + WORD_SPAN);
        wait_idle("bound_idle", fall);
        chk("bound_nbytes", rx_q.size(), 12);
        chk_word("bound_wA", 0, 32'hCAFEF00D);
        chk_word("bound_wB", 4, 32'h12345678);
        chk_word("bound_wC", 8, 32'h9ABCDEF1);
        chk("bound_ovf", overflow, 1'b0);

        // Reset during bit 4 of byte 2
        repeat (5) @(negedge clk);
        strobe_at(32'h87654321, 0);
        s0 = last_strobe;
        while (cyc < s0 + 200) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_txd", TxD, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        clear_rx();
        repeat (5) @(negedge clk);
        strobe_at(32'h0F1E2D3C, 0);
        wait_idle("midrst_idle", fall);
        repeat (5) @(negedge clk);
        chk("midrst_nbytes", rx_q.size(), 4);
        chk_word("midrst_word", 0, 32'h0F1E2D3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
